aes_key_expansion: RTL and testbench
====================================

# aes_key_expansion

Iterative AES key schedule generator. A single `start` pulse expands a 128- or 256-bit cipher key into its round keys and streams them out one 128-bit round key per clock. Round key 0 appears combinationally while the block is idle. It sits in front of the round-key store of the AES datapath; one instance is built per key size through a parameter.

## Interface
- `KEY_BITS`, default 128: cipher key size; legal values are 128 and 256. Derived values: Nk = KEY_BITS/32, Nr = Nk+6, Nr+1 round keys.
- `clk` (input, 1): clock; all state is updated on the rising edge.
- `reset` (input, 1): reset, synchronous, active-low; clock clk.
- `start` (input, 1): begin expansion; sampled on the rising edge while idle.
- `key` (input, KEY_BITS): cipher key; word w0 = `key[KEY_BITS-1 -: 32]` (big-endian, FIPS-197 byte order).
- `subkey` (output, 128): current round key; word w[4k] occupies `[127:96]`.
- `busy` (output, 1): high while round keys 1..Nr are being presented.

## Operation
- Idle (busy=0): `subkey = key[KEY_BITS-1 -: 128]` (round key 0), combinationally from `key`.
- Idle + start=1 at an edge:
  - capture the key into an internal Nk-word window;
  - set the round counter to 1;
  - go busy.
  - After that edge, `key` may change freely.
- Busy, round counter r (1..Nr): `subkey` is registered round key r = words w[4r..4r+3].
  - Each edge computes the next 4 words and increments r.
  - When r = Nr, the next edge returns the block to idle.
- Word recurrence: w[i] = w[i-Nk] ^ t.
  - i mod Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk],24'h0}.
  - Nk == 8 and i mod 8 == 4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. For 256-bit keys, only Rcon 01..40 are used.
- 256-bit case: round key 1 is `key[127:0]` with no computation. Round keys 2..14 alternate between "rot+sub+rcon" and "sub only" for their first word.
- start while busy: ignored. The sequence continues unchanged.
- reset=0 at an edge: busy←0 and round counter←0, taking priority over start. Reset mid-sequence aborts the expansion; `subkey` reverts to idle behaviour.

## Timing
- Count the edge that samples start as edge 1. Round key k (1 ≤ k ≤ Nr) is valid from edge k until edge k+1.
- busy is high after edges 1..Nr and low after edge Nr+1.
- 128-bit: 10 busy cycles. 256-bit: 14 busy cycles.
- Throughput: one round key per cycle. A new start is accepted on the first idle edge, so back-to-back expansions are possible.
- Reset values: busy=0. `subkey` follows the idle rule.
- Critical path, per cycle: one SubWord (4 S-box lookups) plus four chained 32-bit XORs.

## Structure
- Shared package `aes_pkg` holds:
  - 256-entry S-box constant table;
  - Rcon table (10 bytes);
  - `rot_word` and `sub_word` functions;
  - a type for a 32-bit word.
- Sub-module `aes_sbox`: combinational byte → byte lookup. Instantiated 4× for SubWord; only one SubWord is needed per cycle for both key sizes.
- Top-level state:
  - Nk×32-bit word window;
  - 4-bit round counter;
  - busy flag;
  - Nk-position phase (for 256: even/odd round-key selection).

## Test plan
- 128-bit FIPS-197 A.1: key=2b7e151628aed2a6abf7158809cf4f3c, pulse start.
  - Idle subkey = key.
  - Edge 1: a0fafe1788542cb123a339392a6c7605.
  - Edge 10: d014f9a8c9ee2589e13f0cc8b6630ca6.
  - busy high for exactly 10 cycles.
- 256-bit FIPS-197 A.3: key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Idle: 603deb1015ca71be2b73aef0857d7781.
  - Edge 1: 1f352c073b6108d72d9810a30914dff4.
  - Edge 2: 9ba354118e6925afa51a8b5f2067fcde.
  - Edge 14: fe4890d1e6188d0b046df344706c631e.
  - busy high for 14 cycles.
- Key change after start (128-bit): change key to all-zero after edge 1 → sequence still matches A.1 through edge 10.
- start held high for 3 cycles mid-sequence → no restart; edge-10 key is still d014f9a8…; a start on the first idle edge restarts a fresh sequence.
- reset=0 at edge 5 → busy=0 next cycle and subkey = key[127:0]; a new start after reset produces a full correct sequence.
- Back-to-back: second start asserted with busy=0 immediately after completion → edge-1 key of the second expansion is correct, with no lost cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// AES key-schedule shared definitions: word type, S-box, Rcon,
// and the RotWord / SubWord helpers.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in, one byte out, combinational.
// Ports: data = input byte, sub = substituted byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  assign sub = SBOX[data];

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128/256 key schedule, one round key per clock.
// Ports: clk, reset (sync, low), start, key -> subkey, busy.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key,
  output logic [127:0]        subkey,
  output logic                busy
);

  localparam int NK = KEY_BITS / 32;
  localparam logic [3:0] NR = 4'(NK + 6);

  word_t      win [NK];
  word_t      key_w [NK];
  word_t      src [4];
  word_t      nxt [4];
  word_t      last;
  word_t      sub_in;
  word_t      sub_out;
  word_t      t;
  logic [3:0] round;
  logic [3:0] rc_idx;
  logic [3:0] rc_sel;
  logic [7:0] rc;
  logic       phase;
  logic       take;

  for (genvar j = 0; j < NK; j++) begin : g_key
    assign key_w[j] = key[KEY_BITS-1-32*j -: 32];
  end

  // Idle: derive from the key (128-bit start edge).
  // Busy: derive from the oldest four window words.
  for (genvar j = 0; j < 4; j++) begin : g_src
    assign src[j] = busy ? win[j] : key_w[j];
  end

  assign last   = busy ? win[NK-1] : key_w[NK-1];
  assign sub_in = phase ? rot_word(last) : last;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .data (sub_in[8*b +: 8]),
      .sub  (sub_out[8*b +: 8])
    );
  end

  // Rcon index i/Nk - 1: round for 128, round/2 for 256.
  assign rc_idx = (NK == 4) ? round
                            : {1'b0, round[3:1]};
  assign rc_sel = (rc_idx > 4'd9) ? 4'd9 : rc_idx;
  assign rc     = RCON[rc_sel];
  assign t      = phase ? (sub_out ^ {rc, 24'h0})
                        : sub_out;

  assign nxt[0] = src[0] ^ t;
  assign nxt[1] = src[1] ^ nxt[0];
  assign nxt[2] = src[2] ^ nxt[1];
  assign nxt[3] = src[3] ^ nxt[2];

  assign take = !busy && start;

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy  <= 1'b0;
      round <= 4'd0;
      phase <= 1'b1;
    end else if (take) begin
      busy  <= 1'b1;
      round <= 4'd1;
      phase <= 1'b1;
    end else if (busy) begin
      if (round == NR) begin
        busy  <= 1'b0;
        round <= 4'd0;
        phase <= 1'b1;
      end else begin
        round <= round + 4'd1;
        phase <= (NK == 4) ? 1'b1 : ~phase;
      end
    end
  end

  if (NK == 4) begin : g_k128
    always_ff @(posedge clk) begin
      if (take || busy) begin
        for (int j = 0; j < 4; j++) begin
          win[j] <= nxt[j];
        end
      end
    end
  end else begin : g_k256
    // Round key 1 is the key's second half, so
    // the start edge just loads the raw key.
    always_ff @(posedge clk) begin
      if (take) begin
        for (int j = 0; j < NK; j++) begin
          win[j] <= key_w[j];
        end
      end else if (busy) begin
        for (int j = 0; j < 4; j++) begin
          win[j]   <= win[j+4];
          win[j+4] <= nxt[j];
        end
      end
    end
  end

  assign subkey = busy ? {win[NK-4], win[NK-3],
                          win[NK-2], win[NK-1]}
                       : key[KEY_BITS-1 -: 128];

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion, 128 and 256 bit.
// Reference schedule built from GF(2^8) arithmetic.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic [127:0] key_a = '0;
  logic [255:0] key_b = '0;
  logic [127:0] subkey_a;
  logic [127:0] subkey_b;
  logic         busy_a;
  logic         busy_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_m [256];
  logic [7:0]  rcon_m [11];
  logic [31:0] mw [60];

  always #5 clk = ~clk;

  aes_key_expansion #(.KEY_BITS(128)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .start  (start_a),
    .key    (key_a),
    .subkey (subkey_a),
    .busy   (busy_a)
  );

  aes_key_expansion #(.KEY_BITS(256)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .start  (start_b),
    .key    (key_b),
    .subkey (subkey_b),
    .busy   (busy_b)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x,
                                       input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^
           rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]],
            sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k,
                              input int nk);
    logic [31:0] tmp;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      tmp = mw[i-1];
      if (i % nk == 0)
        tmp = sw({tmp[23:0], tmp[31:24]}) ^
              {rcon_m[i/nk], 24'h0};
      else if (nk == 8 && i % 8 == 4)
        tmp = sw(tmp);
      mw[i] = mw[i-nk] ^ tmp;
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    key_a = rnd128();
    key_b = {rnd128(), rnd128()};
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b%b exp 00",
               busy_a, busy_b);
    end
    checks++;
    if (subkey_a !== key_a) begin
      errors++;
      $display("FAIL reset_sk128 got %h exp %h",
               subkey_a, key_a);
    end
    checks++;
    if (subkey_b !== key_b[255:128]) begin
      errors++;
      $display("FAIL reset_sk256 got %h exp %h",
               subkey_b, key_b[255:128]);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fips128();
    key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand({key_a, 128'h0}, 4);
    #1;
    checks++;
    if (subkey_a !== key_a || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL a1_idle got %h/%b exp %h/0",
               subkey_a, busy_a, key_a);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      checks++;
      if (subkey_a !== rk(r) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL a1_r%0d got %h/%b exp %h/1",
                 r, subkey_a, busy_a, rk(r));
      end
      if (r == 1) begin
        checks++;
        if (subkey_a !== 128'ha0fafe1788542cb123a339392a6c7605) begin
          errors++;
          $display("FAIL a1_kat1 got %h", subkey_a);
        end
      end
      if (r == 10) begin
        checks++;
        if (subkey_a !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
          errors++;
          $display("FAIL a1_kat10 got %h", subkey_a);
        end
      end
      tick();
    end
    checks++;
    if (busy_a !== 1'b0 || subkey_a !== key_a) begin
      errors++;
      $display("FAIL a1_end got %h/%b exp %h/0",
               subkey_a, busy_a, key_a);
    end
  endtask

  task automatic test_fips256();
    key_b = 256'h603deb1015ca71be2b73aef0857d7781_1f352c073b6108d72d9810a30914dff4;
    model_expand(key_b, 8);
    #1;
    checks++;
    if (subkey_b !== 128'h603deb1015ca71be2b73aef0857d7781
        || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL a3_idle got %h/%b", subkey_b, busy_b);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int r = 1; r <= 14; r++) begin
      checks++;
      if (subkey_b !== rk(r) || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL a3_r%0d got %h/%b exp %h/1",
                 r, subkey_b, busy_b, rk(r));
      end
      if (r == 1) begin
        checks++;
        if (subkey_b !== 128'h1f352c073b6108d72d9810a30914dff4) begin
          errors++;
          $display("FAIL a3_kat1 got %h", subkey_b);
        end
      end
      if (r == 2) begin
        checks++;
        if (subkey_b !== 128'h9ba354118e6925afa51a8b5f2067fcde) begin
          errors++;
          $display("FAIL a3_kat2 got %h", subkey_b);
        end
      end
      if (r == 14) begin
        checks++;
        if (subkey_b !== 128'hfe4890d1e6188d0b046df344706c631e) begin
          errors++;
          $display("FAIL a3_kat14 got %h", subkey_b);
        end
      end
      tick();
    end
    checks++;
    if (busy_b !== 1'b0 || subkey_b !== key_b[255:128]) begin
      errors++;
      $display("FAIL a3_end got %h/%b", subkey_b, busy_b);
    end
  endtask

  task automatic test_key_change();
    key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand({key_a, 128'h0}, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    key_a = '0;
    for (int r = 1; r <= 10; r++) begin
      checks++;
      if (subkey_a !== rk(r) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL kchg_r%0d got %h/%b exp %h/1",
                 r, subkey_a, busy_a, rk(r));
      end
      tick();
    end
    checks++;
    if (busy_a !== 1'b0 || subkey_a !== 128'h0) begin
      errors++;
      $display("FAIL kchg_end got %h/%b exp 0/0",
               subkey_a, busy_a);
    end
  endtask

  task automatic test_start_ignored();
    key_a = rnd128();
    model_expand({key_a, 128'h0}, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      checks++;
      if (subkey_a !== rk(r) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL hold_r%0d got %h/%b exp %h/1",
                 r, subkey_a, busy_a, rk(r));
      end
      if (r == 3) start_a = 1'b1;
      if (r == 6) start_a = 1'b0;
      tick();
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL hold_end busy got %b exp 0", busy_a);
    end
    key_a = rnd128();
    model_expand({key_a, 128'h0}, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      checks++;
      if (subkey_a !== rk(r) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL restart_r%0d got %h/%b exp %h/1",
                 r, subkey_a, busy_a, rk(r));
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    key_a = rnd128();
    model_expand({key_a, 128'h0}, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      checks++;
      if (subkey_a !== rk(r) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL rst_r%0d got %h/%b exp %h/1",
                 r, subkey_a, busy_a, rk(r));
      end
      if (r < 4) tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (busy_a !== 1'b0 || subkey_a !== key_a) begin
      errors++;
      $display("FAIL rst_abort got %h/%b exp %h/0",
               subkey_a, busy_a, key_a);
    end
    key_a = rnd128();
    model_expand({key_a, 128'h0}, 4);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      checks++;
      if (subkey_a !== rk(r) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL rst_new_r%0d got %h/%b exp %h/1",
                 r, subkey_a, busy_a, rk(r));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      key_a = rnd128();
      model_expand({key_a, 128'h0}, 4);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int r = 1; r <= 10; r++) begin
        checks++;
        if (subkey_a !== rk(r) || busy_a !== 1'b1) begin
          errors++;
          $display("FAIL b2b128_%0d_r%0d got %h/%b exp %h/1",
                   n, r, subkey_a, busy_a, rk(r));
        end
        tick();
      end
      checks++;
      if (busy_a !== 1'b0) begin
        errors++;
        $display("FAIL b2b128_%0d_idle got %b", n, busy_a);
      end
    end
    for (int n = 0; n < 2; n++) begin
      key_b = {rnd128(), rnd128()};
      model_expand(key_b, 8);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int r = 1; r <= 14; r++) begin
        checks++;
        if (subkey_b !== rk(r) || busy_b !== 1'b1) begin
          errors++;
          $display("FAIL b2b256_%0d_r%0d got %h/%b exp %h/1",
                   n, r, subkey_b, busy_b, rk(r));
        end
        tick();
      end
      checks++;
      if (busy_b !== 1'b0) begin
        errors++;
        $display("FAIL b2b256_%0d_idle got %b", n, busy_b);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      key_b = {rnd128(), rnd128()};
      model_expand(key_b, 8);
      #1;
      checks++;
      if (subkey_b !== key_b[255:128]) begin
        errors++;
        $display("FAIL rnd256_%0d_idle got %h exp %h",
                 n, subkey_b, key_b[255:128]);
      end
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int r = 1; r <= 14; r++) begin
        checks++;
        if (subkey_b !== rk(r) || busy_b !== 1'b1) begin
          errors++;
          $display("FAIL rnd256_%0d_r%0d got %h/%b exp %h/1",
                   n, r, subkey_b, busy_b, rk(r));
        end
        tick();
      end
      tick();
    end
  endtask

  initial begin
    logic [7:0] rc;
    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_ref(8'(i));
    rc = 8'h01;
    rcon_m[0] = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      rcon_m[i] = rc;
      rc = xtime(rc);
    end
    test_reset();
    test_fips128();
    test_fips256();
    test_key_change();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
